mfcc_feature_collector: RTL and testbench

//  Consumer end of the MFCC coefficient stream (mfcc/mfcc_valid, 13 coefs per frame, c0 first).

---
 rtl/mfcc_feature_collector_pkg.sv | 31 +++
 rtl/mfcc_feat_ram.sv | 31 +++
 rtl/mfcc_feature_collector.sv | 134 +++++++++++++
 tb/tb_mfcc_feature_collector.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfcc_feature_collector_pkg.sv
// rtl/mfcc_feature_collector_pkg.sv - shared MFCC feature buffer parameters and types
package mfcc_feature_collector_pkg;

  localparam int N_COEF      = 13;
  localparam int MAX_FRAMES  = 64;
  localparam int COEF_STRIDE = 16;
  localparam int DW          = 16;
  localparam int MFCC_FRAC   = 8;

  localparam int FRAME_W = $clog2(MAX_FRAMES);
  localparam int COEF_W  = $clog2(COEF_STRIDE);
  localparam int ADDR_W  = FRAME_W + COEF_W;
  localparam int CNT_W   = FRAME_W + 1;
  localparam int DEPTH   = MAX_FRAMES * COEF_STRIDE;

  localparam logic [COEF_W-1:0] LAST_COEF  = COEF_W'(N_COEF - 1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(MAX_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Stride is a power of two, so the frame index simply sits above the coefficient index.
  function automatic logic [ADDR_W-1:0] feat_addr(input logic [FRAME_W-1:0] frame,
                                                  input logic [COEF_W-1:0]  coef);
    return {frame, coef};
  endfunction

endpackage

// File: rtl/mfcc_feat_ram.sv
// rtl/mfcc_feat_ram.sv - simple dual-port feature RAM with registered read port
module mfcc_feat_ram
  import mfcc_feature_collector_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DW-1:0]     rd_data
);

  logic [DW-1:0] r_mem [0:DEPTH-1];
  logic [DW-1:0] r_rd_data;

  // Write port; contents are deliberately never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Read port: a same-cycle write to the same address returns the old word; holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_rd_data <= '0;
    else if (rd_en) r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/mfcc_feature_collector.sv
// rtl/mfcc_feature_collector.sv - frames the MFCC coefficient stream into a per-utterance feature buffer
module mfcc_feature_collector
  import mfcc_feature_collector_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DW-1:0]      mfcc,
  input  logic               mfcc_valid,
  output logic               capturing,
  output logic               frame_done,
  output logic               feat_ready,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic               overflow,
  input  logic               rd_en,
  input  logic [FRAME_W-1:0] rd_frame,
  input  logic [COEF_W-1:0]  rd_coef,
  output logic [DW-1:0]      rd_data,
  output logic               rd_valid
);

  state_t              r_state;
  state_t              w_next_state;
  logic [COEF_W-1:0]   r_coef_idx;
  logic [FRAME_W-1:0]  r_wr_frame;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic                r_overflow;
  logic                r_frame_done;
  logic                r_feat_ready;
  logic                r_rd_valid;

  logic                w_cap;
  logic                w_full;
  logic                w_last;
  logic                w_sample;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [ADDR_W-1:0]   w_rd_addr;

  assign w_cap     = (r_state == ST_CAPTURE);
  assign w_full    = (r_frame_cnt == FULL_COUNT);
  assign w_last    = (r_coef_idx == LAST_COEF);
  // A start in the same cycle as a sample restarts capture and drops that sample.
  assign w_sample  = w_cap && mfcc_valid && !start;
  assign w_wr_en   = w_sample && !w_full;
  assign w_wr_addr = feat_addr(r_wr_frame, r_coef_idx);
  assign w_rd_addr = feat_addr(rd_frame, rd_coef);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: start always wins over stop.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next_state = ST_CAPTURE;
      ST_CAPTURE: if (start) w_next_state = ST_CAPTURE;
                  else if (stop) w_next_state = ST_DONE;
      ST_DONE:    if (start) w_next_state = ST_CAPTURE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    capturing = (r_state == ST_CAPTURE);
  end

  // Coefficient/frame counters, commit and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coef_idx  <= '0;
      r_wr_frame  <= '0;
      r_frame_cnt <= '0;
      r_overflow  <= 1'b0;
    end else if (start) begin
      r_coef_idx  <= '0;
      r_wr_frame  <= '0;
      r_frame_cnt <= '0;
      r_overflow  <= 1'b0;
    end else if (w_cap) begin
      if (mfcc_valid) begin
        if (w_last) begin
          r_coef_idx <= '0;
          if (!w_full) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            r_wr_frame  <= r_wr_frame + 1'b1;
          end else begin
            r_overflow  <= 1'b1;
          end
        end else begin
          r_coef_idx <= r_coef_idx + 1'b1;
        end
      end
      // The sample in the stop cycle is handled above; any partial frame is then dropped.
      if (stop) r_coef_idx <= '0;
    end
  end

  // Single-cycle status pulses and the read-valid pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
      r_feat_ready <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_frame_done <= w_sample && w_last && !w_full;
      r_feat_ready <= w_cap && stop && !start;
      r_rd_valid   <= rd_en;
    end
  end

  assign frame_done = r_frame_done;
  assign feat_ready = r_feat_ready;
  assign frame_cnt  = r_frame_cnt;
  assign overflow   = r_overflow;
  assign rd_valid   = r_rd_valid;

  mfcc_feat_ram u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_en),
    .wr_addr (w_wr_addr),
    .wr_data (mfcc),
    .rd_en   (rd_en),
    .rd_addr (w_rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_mfcc_feature_collector.sv
// tb/tb_mfcc_feature_collector.sv - self-checking bench for mfcc_feature_collector
module tb_mfcc_feature_collector;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] mfcc;
  logic        mfcc_valid;
  logic        capturing;
  logic        frame_done;
  logic        feat_ready;
  logic [6:0]  frame_cnt;
  logic        overflow;
  logic        rd_en;
  logic [5:0]  rd_frame;
  logic [3:0]  rd_coef;
  logic [15:0] rd_data;
  logic        rd_valid;

  int total;
  int bad;
  int done_cnt;
  int ready_cnt;

  // Reference model: an utterance is a list of frames of 13 coefficients; at most 64 kept.
  logic [15:0] m_mem [64][13];
  logic [15:0] m_part [$];
  int          m_frames;
  bit          m_ovf;

  mfcc_feature_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mfcc       (mfcc),
    .mfcc_valid (mfcc_valid),
    .capturing  (capturing),
    .frame_done (frame_done),
    .feat_ready (feat_ready),
    .frame_cnt  (frame_cnt),
    .overflow   (overflow),
    .rd_en      (rd_en),
    .rd_frame   (rd_frame),
    .rd_coef    (rd_coef),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (feat_ready === 1'b1) ready_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_start();
    m_part.delete();
    m_frames = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_feed(input logic [15:0] v);
    m_part.push_back(v);
    if (m_part.size() == 13) begin
      if (m_frames < 64) begin
        for (int k = 0; k < 13; k++) m_mem[m_frames][k] = m_part[k];
        m_frames++;
      end else begin
        m_ovf = 1'b1;
      end
      m_part.delete();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_start();
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    m_part.delete();
  endtask

  task automatic drive_coef(input logic [15:0] v, input bit with_stop);
    mfcc = v;
    mfcc_valid = 1'b1;
    stop = with_stop;
    tick();
    mfcc_valid = 1'b0;
    stop = 1'b0;
    model_feed(v);
    if (with_stop) m_part.delete();
  endtask

  task automatic do_read(input int f, input int k);
    rd_en = 1'b1;
    rd_frame = 6'(f);
    rd_coef = 4'(k);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++; if (capturing !== 1'b0) begin bad++; $display("FAIL reset_capturing got=%0b exp=0", capturing); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%0b exp=0", frame_done); end
    total++; if (feat_ready !== 1'b0) begin bad++; $display("FAIL reset_feat_ready got=%0b exp=0", feat_ready); end
    total++; if (frame_cnt !== 7'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    total++; if (rd_data !== 16'd0) begin bad++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_three_frames();
    int d0;
    d0 = done_cnt;
    pulse_start();
    total++; if (capturing !== 1'b1) begin bad++; $display("FAIL tf_capturing got=%0b exp=1", capturing); end
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 13; k++) drive_coef(16'(k + 100 * f), 1'b0);
    tick();
    tick();
    total++; if (done_cnt - d0 !== 3) begin bad++; $display("FAIL tf_frame_done_count got=%0d exp=3", done_cnt - d0); end
    total++; if (frame_cnt !== 7'(m_frames)) begin bad++; $display("FAIL tf_frame_cnt got=%0d exp=%0d", frame_cnt, m_frames); end
    do_read(2, 5);
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL tf_rd_valid got=%0b exp=1", rd_valid); end
    total++; if (rd_data !== 16'd205) begin bad++; $display("FAIL tf_rd_data got=%0d exp=205", rd_data); end
    tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL tf_rd_valid_drop got=%0b exp=0", rd_valid); end
    total++; if (rd_data !== 16'd205) begin bad++; $display("FAIL tf_rd_hold got=%0d exp=205", rd_data); end
  endtask

  task automatic test_partial_stop();
    int r0;
    pulse_start();
    r0 = ready_cnt;
    for (int i = 0; i < 20; i++) drive_coef(16'($urandom_range(9999)), 1'b0);
    pulse_stop();
    total++; if (feat_ready !== 1'b1) begin bad++; $display("FAIL ps_feat_ready_pulse got=%0b exp=1", feat_ready); end
    total++; if (capturing !== 1'b0) begin bad++; $display("FAIL ps_capturing got=%0b exp=0", capturing); end
    tick();
    tick();
    total++; if (ready_cnt - r0 !== 1) begin bad++; $display("FAIL ps_feat_ready_count got=%0d exp=1", ready_cnt - r0); end
    total++; if (frame_cnt !== 7'(m_frames)) begin bad++; $display("FAIL ps_frame_cnt got=%0d exp=%0d", frame_cnt, m_frames); end
    pulse_start();
    for (int k = 0; k < 13; k++) drive_coef(16'(500 + k), 1'b0);
    tick();
    total++; if (frame_cnt !== 7'd1) begin bad++; $display("FAIL ps_restart_cnt got=%0d exp=1", frame_cnt); end
    do_read(0, 3);
    total++; if (rd_data !== 16'd503) begin bad++; $display("FAIL ps_frame0_data got=%0d exp=503", rd_data); end
  endtask

  task automatic test_overflow();
    int d0;
    int f;
    int k;
    pulse_start();
    d0 = done_cnt;
    for (int i = 0; i < 65 * 13; i++) drive_coef(16'($urandom), 1'b0);
    tick();
    tick();
    total++; if (frame_cnt !== 7'(m_frames)) begin bad++; $display("FAIL ov_frame_cnt got=%0d exp=%0d", frame_cnt, m_frames); end
    total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ov_overflow got=%0b exp=%0b", overflow, m_ovf); end
    total++; if (done_cnt - d0 !== 64) begin bad++; $display("FAIL ov_frame_done_count got=%0d exp=64", done_cnt - d0); end
    do_read(0, 0);
    total++; if (rd_data !== m_mem[0][0]) begin bad++; $display("FAIL ov_first got=%0h exp=%0h", rd_data, m_mem[0][0]); end
    do_read(63, 12);
    total++; if (rd_data !== m_mem[63][12]) begin bad++; $display("FAIL ov_last got=%0h exp=%0h", rd_data, m_mem[63][12]); end
    for (int i = 0; i < 30; i++) begin
      f = $urandom_range(63);
      k = $urandom_range(12);
      do_read(f, k);
      total++; if (rd_data !== m_mem[f][k]) begin bad++; $display("FAIL ov_read f=%0d k=%0d got=%0h exp=%0h", f, k, rd_data, m_mem[f][k]); end
    end
  endtask

  task automatic test_stop_with_last();
    pulse_start();
    for (int k = 0; k < 12; k++) drive_coef(16'(300 + k), 1'b0);
    drive_coef(16'd312, 1'b1);
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL sl_frame_done got=%0b exp=1", frame_done); end
    total++; if (feat_ready !== 1'b1) begin bad++; $display("FAIL sl_feat_ready got=%0b exp=1", feat_ready); end
    total++; if (frame_cnt !== 7'(m_frames)) begin bad++; $display("FAIL sl_frame_cnt got=%0d exp=%0d", frame_cnt, m_frames); end
    total++; if (capturing !== 1'b0) begin bad++; $display("FAIL sl_capturing got=%0b exp=0", capturing); end
    do_read(0, 12);
    total++; if (rd_data !== 16'd312) begin bad++; $display("FAIL sl_data got=%0d exp=312", rd_data); end
  endtask

  task automatic test_restart();
    int r0;
    pulse_start();
    for (int k = 0; k < 13 + 5; k++) drive_coef(16'(k), 1'b0);
    r0 = ready_cnt;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    model_start();
    total++; if (capturing !== 1'b1) begin bad++; $display("FAIL rs_capturing got=%0b exp=1", capturing); end
    total++; if (frame_cnt !== 7'd0) begin bad++; $display("FAIL rs_frame_cnt got=%0d exp=0", frame_cnt); end
    for (int k = 0; k < 13; k++) drive_coef(16'(700 + k), 1'b0);
    tick();
    total++; if (ready_cnt - r0 !== 0) begin bad++; $display("FAIL rs_no_feat_ready got=%0d exp=0", ready_cnt - r0); end
    total++; if (frame_cnt !== 7'(m_frames)) begin bad++; $display("FAIL rs_aligned_cnt got=%0d exp=%0d", frame_cnt, m_frames); end
    do_read(0, 0);
    total++; if (rd_data !== 16'd700) begin bad++; $display("FAIL rs_aligned_data got=%0d exp=700", rd_data); end
  endtask

  task automatic test_back_to_back();
    int n;
    int d0;
    int r0;
    int f;
    int k;
    for (int u = 0; u < 3; u++) begin
      pulse_start();
      d0 = done_cnt;
      r0 = ready_cnt;
      n = $urandom_range(120);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(3) == 0) tick();
        drive_coef(16'($urandom), 1'b0);
      end
      pulse_stop();
      tick();
      total++; if (frame_cnt !== 7'(m_frames)) begin bad++; $display("FAIL bb_frame_cnt u=%0d got=%0d exp=%0d", u, frame_cnt, m_frames); end
      total++; if (done_cnt - d0 !== m_frames) begin bad++; $display("FAIL bb_done u=%0d got=%0d exp=%0d", u, done_cnt - d0, m_frames); end
      total++; if (ready_cnt - r0 !== 1) begin bad++; $display("FAIL bb_ready u=%0d got=%0d exp=1", u, ready_cnt - r0); end
      for (int i = 0; i < 4 && m_frames > 0; i++) begin
        f = $urandom_range(m_frames - 1);
        k = $urandom_range(12);
        do_read(f, k);
        total++; if (rd_data !== m_mem[f][k]) begin bad++; $display("FAIL bb_read f=%0d k=%0d got=%0h exp=%0h", f, k, rd_data, m_mem[f][k]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    pulse_start();
    for (int k = 0; k < 13; k++) drive_coef(16'(1000 + k), 1'b0);
    for (int k = 0; k < 7; k++) drive_coef(16'(k), 1'b0);
    do_read(0, 0);
    mfcc = 16'd7;
    mfcc_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (capturing !== 1'b0) begin bad++; $display("FAIL rm_capturing got=%0b exp=0", capturing); end
    total++; if (frame_cnt !== 7'd0) begin bad++; $display("FAIL rm_frame_cnt got=%0d exp=0", frame_cnt); end
    total++; if (rd_data !== 16'd0) begin bad++; $display("FAIL rm_rd_data got=%0d exp=0", rd_data); end
    total++; if (frame_done !== 1'b0 || feat_ready !== 1'b0 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL rm_flags got=%0b%0b%0b%0b exp=0000", frame_done, feat_ready, overflow, rd_valid);
    end
    mfcc_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    d0 = done_cnt;
    for (int k = 0; k < 13; k++) begin
      mfcc = 16'(k);
      mfcc_valid = 1'b1;
      tick();
    end
    mfcc_valid = 1'b0;
    tick();
    tick();
    total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL rm_idle_done got=%0d exp=0", done_cnt - d0); end
    total++; if (frame_cnt !== 7'd0) begin bad++; $display("FAIL rm_idle_cnt got=%0d exp=0", frame_cnt); end
    total++; if (capturing !== 1'b0) begin bad++; $display("FAIL rm_idle_capturing got=%0b exp=0", capturing); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    done_cnt = 0;
    ready_cnt = 0;
    start = 1'b0;
    stop = 1'b0;
    mfcc = '0;
    mfcc_valid = 1'b0;
    rd_en = 1'b0;
    rd_frame = '0;
    rd_coef = '0;
    model_start();
    test_reset();
    test_three_frames();
    test_partial_stop();
    test_overflow();
    test_stop_with_last();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
